// File: rtl/intpol2_mc_ctrl_fsm_if.sv
// rtl/intpol2_mc_ctrl_fsm_if.sv - FIFO handshake, config and datapath strobe bundle for the intpol2 controller
interface intpol2_mc_ctrl_fsm_if #(
   parameter int NCH        = 2,
   parameter int MAX_L_LOG2 = 4
);
   localparam int LW = $clog2(MAX_L_LOG2 + 1);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   logic                  start;
   logic                  stop_req;
   logic                  bypass;
   logic [LW-1:0]         l_log2;
   logic                  Empty;
   logic                  Afull;
   logic                  busy;
   logic                  Read_Enable;
   logic                  Write_Enable;
   logic                  op_1;
   logic                  Ld_p1_xi;
   logic                  en_sum;
   logic                  en_stream;
   logic                  sel_mult;
   logic                  stop_empty;
   logic                  stop_Afull;
   logic                  done;
   logic                  clear;
   logic [CW-1:0]         ch_idx;
   logic [MAX_L_LOG2-1:0] phase;

   modport master (
      input  start, stop_req, bypass, l_log2, Empty, Afull,
      output busy, Read_Enable, Write_Enable, op_1, Ld_p1_xi, en_sum, en_stream,
             sel_mult, stop_empty, stop_Afull, done, clear, ch_idx, phase
   );

   modport slave (
      output start, stop_req, bypass, l_log2, Empty, Afull,
      input  busy, Read_Enable, Write_Enable, op_1, Ld_p1_xi, en_sum, en_stream,
             sel_mult, stop_empty, stop_Afull, done, clear, ch_idx, phase
   );
endinterface

// File: rtl/intpol2_mc_ctrl_fsm.sv
// rtl/intpol2_mc_ctrl_fsm.sv - multichannel, runtime-L control FSM for the 2nd-order polynomial interpolator
module intpol2_mc_ctrl_fsm #(
   parameter int NCH        = 2,
   parameter int MAX_L_LOG2 = 4,
   parameter int PRELOAD_N  = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   intpol2_mc_ctrl_fsm_if.master  bus
);
   localparam int LW = $clog2(MAX_L_LOG2 + 1);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int RW = $clog2(PRELOAD_N * NCH + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_PRELOAD, S_COEF, S_LDP, S_OUT, S_FDONE, S_FETCH, S_SHIFT, S_BYPASS, S_CLEAR
   } state_t;

   state_t                state, state_nx;
   logic [LW-1:0]         l_q;
   logic [CW-1:0]         ch_q;
   logic [MAX_L_LOG2-1:0] ph_q;
   logic [RW-1:0]         rd_cnt;
   logic                  stop_lat;

   logic [LW-1:0]         l_clamp;
   logic [MAX_L_LOG2:0]   l_full;
   logic                  ph_last, ch_last, rd_acc, rd_last, sample_cfg, stop_pend;

   assign l_clamp    = (bus.l_log2 > LW'(MAX_L_LOG2)) ? LW'(MAX_L_LOG2) : bus.l_log2;
   assign l_full     = (MAX_L_LOG2+1)'(1) << l_q;
   assign ph_last    = ({1'b0, ph_q} == (l_full - (MAX_L_LOG2+1)'(1)));
   assign ch_last    = (ch_q == CW'(NCH - 1));
   assign rd_acc     = bus.Read_Enable & ~bus.Empty;
   assign rd_last    = (state == S_PRELOAD) ? (rd_cnt == RW'(PRELOAD_N * NCH - 1))
                                            : (rd_cnt == RW'(NCH - 1));
   assign sample_cfg = (bus.start & (state == S_IDLE)) | (~bus.start & (state == S_CLEAR));
   assign stop_pend  = stop_lat | bus.stop_req;
   assign bus.ch_idx = ch_q;
   assign bus.phase  = ph_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Counters and latch; start anywhere wipes them so a restart begins from channel 0, phase 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         l_q      <= '0;
         ch_q     <= '0;
         ph_q     <= '0;
         rd_cnt   <= '0;
         stop_lat <= 1'b0;
      end else begin
         if (sample_cfg) l_q <= l_clamp;
         if (bus.start) begin
            ch_q     <= '0;
            ph_q     <= '0;
            rd_cnt   <= '0;
            stop_lat <= 1'b0;
         end else begin
            if (bus.busy) stop_lat <= stop_lat | bus.stop_req;
            case (state)
               S_PRELOAD, S_FETCH: if (rd_acc) rd_cnt <= rd_last ? '0 : rd_cnt + RW'(1);
               S_OUT: begin
                  if (!bus.Afull) begin
                     if (ph_last) begin
                        ph_q <= '0;
                        if (!ch_last) ch_q <= ch_q + CW'(1);
                     end else begin
                        ph_q <= ph_q + MAX_L_LOG2'(1);
                     end
                  end
               end
               S_FDONE: begin
                  ch_q <= '0;
                  if (stop_pend) stop_lat <= 1'b0;
               end
               S_BYPASS: if (stop_pend) stop_lat <= 1'b0;
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_nx         = state;
      bus.busy         = (state != S_IDLE) && (state != S_CLEAR);
      bus.Read_Enable  = 1'b0;
      bus.Write_Enable = 1'b0;
      bus.op_1         = 1'b0;
      bus.Ld_p1_xi     = 1'b0;
      bus.en_sum       = 1'b0;
      bus.en_stream    = 1'b0;
      bus.sel_mult     = 1'b0;
      bus.stop_empty   = 1'b0;
      bus.stop_Afull   = 1'b0;
      bus.done         = 1'b0;
      if (bus.start && (state != S_IDLE)) begin
         state_nx = S_CLEAR;
      end else begin
         unique case (state)
            S_IDLE:  if (bus.start) state_nx = bus.bypass ? S_BYPASS : S_PRELOAD;
            S_CLEAR: state_nx = bus.bypass ? S_BYPASS : S_PRELOAD;
            S_PRELOAD, S_FETCH: begin
               bus.Read_Enable = ~bus.Empty;
               bus.stop_empty  = bus.Empty;
               if (rd_acc && rd_last) state_nx = (state == S_PRELOAD) ? S_COEF : S_SHIFT;
            end
            S_COEF: begin
               bus.op_1 = 1'b1;
               state_nx = S_LDP;
            end
            S_LDP: begin
               bus.Ld_p1_xi = 1'b1;
               state_nx     = S_OUT;
            end
            S_OUT: begin
               bus.sel_mult = 1'b1;
               if (bus.Afull) begin
                  bus.stop_Afull = 1'b1;
               end else begin
                  bus.Write_Enable = 1'b1;
                  if (!ph_last) begin
                     bus.en_sum = 1'b1;
                     state_nx   = S_LDP;
                  end else begin
                     state_nx = ch_last ? S_FDONE : S_COEF;
                  end
               end
            end
            S_FDONE: begin
               bus.done = 1'b1;
               state_nx = stop_pend ? S_IDLE : S_FETCH;
            end
            S_SHIFT: begin
               bus.en_stream = 1'b1;
               state_nx      = S_COEF;
            end
            S_BYPASS: begin
               // Read and write fire together, so nothing is in flight once the edge passes.
               bus.Read_Enable  = ~bus.Empty & ~bus.Afull;
               bus.Write_Enable = ~bus.Empty & ~bus.Afull;
               bus.stop_empty   = bus.Empty;
               bus.stop_Afull   = bus.Afull;
               if (stop_pend) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
         endcase
      end
      bus.clear = bus.start | bus.done;
   end
endmodule

// File: tb/tb_intpol2_mc_ctrl_fsm.sv
// tb/tb_intpol2_mc_ctrl_fsm.sv - scoreboard bench for intpol2_mc_ctrl_fsm
module tb_intpol2_mc_ctrl_fsm;
   localparam int NCH  = 2;
   localparam int MAXL = 4;

   typedef struct { int ch; int ph; int sum; int cyc; } wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0, checks = 0, errors = 0, op_cnt = 0, done_cyc = 0, t0 = 0, seen = 0;
   wr_t  wr_q[$];
   wr_t  mon_r;
   int   t1_wr[8] = '{9, 11, 13, 15, 18, 20, 22, 24};
   logic [1:0] pat[8] = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b00, 2'b10, 2'b00};

   intpol2_mc_ctrl_fsm_if #(.NCH(NCH), .MAX_L_LOG2(MAXL)) bus ();
   intpol2_mc_ctrl_fsm #(.NCH(NCH), .MAX_L_LOG2(MAXL), .PRELOAD_N(3)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_wr(input int ch, input int ph, input int sum, input int c);
      wr_t r;
      r.ch = ch; r.ph = ph; r.sum = sum; r.cyc = c;
      wr_q.push_back(r);
   endtask

   task automatic push_frame(input int l);
      for (int c = 0; c < NCH; c++)
         for (int p = 0; p < l; p++) push_wr(c, p, (p != l - 1) ? 1 : 0, -1);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
   endtask

   task automatic pulse_stop();
      bus.stop_req = 1'b1;
      @(posedge clk); #1 bus.stop_req = 1'b0;
   endtask

   task automatic wait_done(input int lim);
      int s = 0;
      for (int i = 0; i < lim && s == 0; i++) begin
         @(negedge clk);
         if (bus.done) s = 1;
      end
      done_cyc = cyc;
      check("done_seen", s, 1);
   endtask

   task automatic wait_ld(input int ch, input int ph, input int lim);
      int s = 0;
      for (int i = 0; i < lim && s == 0; i++) begin
         @(negedge clk);
         if (bus.Ld_p1_xi && int'(bus.ch_idx) == ch && int'(bus.phase) == ph) s = 1;
      end
      check("ld_seen", s, 1);
   endtask

   // Monitor: every write must match the next queued expectation.
   always @(negedge clk) begin
      if (bus.Empty) check("re_while_empty", int'(bus.Read_Enable), 0);
      if (bus.op_1) op_cnt++;
      if (bus.Write_Enable) begin
         if (wr_q.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            mon_r = wr_q.pop_front();
            check("wr_ch", int'(bus.ch_idx), mon_r.ch);
            check("wr_phase", int'(bus.phase), mon_r.ph);
            check("wr_en_sum", int'(bus.en_sum), mon_r.sum);
            if (mon_r.cyc >= 0) check("wr_cycle", cyc - t0, mon_r.cyc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.start = 0; bus.stop_req = 0; bus.bypass = 0; bus.l_log2 = 3'd2;
      bus.Empty = 0; bus.Afull = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", int'(bus.busy), 0);
      check("rst_re", int'(bus.Read_Enable), 0);
      check("rst_we", int'(bus.Write_Enable), 0);
      check("rst_clear", int'(bus.clear), 0);
      check("rst_phase", int'(bus.phase), 0);
      bus.start = 1; #1;
      check("rst_clear_eq_start", int'(bus.clear), 1);
      bus.start = 0;
      @(posedge clk); #1 rst = 0;

      // T1: exact timing of the first frame
      op_cnt = 0;
      @(posedge clk); #1 bus.start = 1; t0 = cyc;
      for (int i = 0; i < 8; i++) push_wr(i / 4, i % 4, (i % 4 != 3) ? 1 : 0, t1_wr[i]);
      @(posedge clk); #1 bus.start = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         check("t1_preload_re", int'(bus.Read_Enable), 1);
      end
      @(negedge clk); check("t1_op1_c7", int'(bus.op_1), 1);
      @(negedge clk); check("t1_ld_c8", int'(bus.Ld_p1_xi), 1);
      wait_done(40);
      check("t1_done_cycle", done_cyc - t0, 25);
      check("t1_writes_left", wr_q.size(), 0);
      check("t1_op1_count", op_cnt, 2);
      check("t1_clear_on_done", int'(bus.clear), 1);

      // T2: Afull stall in OUT at phase 2
      push_frame(4);
      wait_ld(0, 2, 40);
      @(posedge clk); #1 bus.Afull = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t2_stop_afull", int'(bus.stop_Afull), 1);
         check("t2_no_write", int'(bus.Write_Enable), 0);
         check("t2_phase_hold", int'(bus.phase), 2);
      end
      @(posedge clk); #1 bus.Afull = 0;
      wait_done(40);
      check("t2_writes_left", wr_q.size(), 0);

      // T3: Empty stall in FETCH
      push_frame(4);
      @(posedge clk); #1 bus.Empty = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t3_stop_empty", int'(bus.stop_empty), 1);
         check("t3_no_read", int'(bus.Read_Enable), 0);
      end
      @(posedge clk); #1 bus.Empty = 0;
      @(negedge clk); check("t3_read0", int'(bus.Read_Enable), 1);
      @(negedge clk); check("t3_read1", int'(bus.Read_Enable), 1);
      @(negedge clk); check("t3_en_stream", int'(bus.en_stream), 1);
      @(negedge clk); check("t3_op1", int'(bus.op_1), 1);

      // T4: graceful stop finishes the frame
      @(posedge clk); #1 pulse_stop();
      wait_done(40);
      check("t4_writes_left", wr_q.size(), 0);
      @(negedge clk); check("t4_idle_busy", int'(bus.busy), 0);

      // T5: start mid-OUT forces CLEAR then a clean restart
      push_wr(0, 0, 1, -1);
      pulse_start();
      wait_ld(0, 1, 40);
      @(posedge clk); #1 bus.start = 1;
      @(negedge clk);
      check("t5_no_we", int'(bus.Write_Enable), 0);
      check("t5_no_sel", int'(bus.sel_mult), 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("t5_clear1_busy", int'(bus.busy), 0);
      check("t5_clear1_re", int'(bus.Read_Enable), 0);
      @(posedge clk); #1 bus.start = 0;
      @(negedge clk);
      check("t5_clear2_busy", int'(bus.busy), 0);
      check("t5_clear2_clear", int'(bus.clear), 0);
      push_frame(4);
      @(negedge clk);
      check("t5_restart_busy", int'(bus.busy), 1);
      check("t5_restart_re", int'(bus.Read_Enable), 1);
      check("t5_restart_ch", int'(bus.ch_idx), 0);
      check("t5_restart_phase", int'(bus.phase), 0);
      @(posedge clk); #1 pulse_stop();
      wait_done(40);
      check("t5_writes_left", wr_q.size(), 0);
      @(negedge clk); check("t5_idle_busy", int'(bus.busy), 0);

      // L = 1: one write per channel, no en_sum
      bus.l_log2 = 3'd0;
      push_frame(1);
      pulse_start();
      pulse_stop();
      wait_done(40);
      check("l1_writes_left", wr_q.size(), 0);
      @(negedge clk); check("l1_idle_busy", int'(bus.busy), 0);

      // l_log2 above MAX clamps to L = 16
      bus.l_log2 = 3'd7;
      push_frame(16);
      pulse_start();
      pulse_stop();
      wait_done(200);
      check("clamp_writes_left", wr_q.size(), 0);
      @(negedge clk); check("clamp_idle_busy", int'(bus.busy), 0);

      // Synchronous reset in mid-operation
      bus.l_log2 = 3'd2;
      pulse_start();
      seen = 0;
      for (int i = 0; i < 20 && seen == 0; i++) begin
         @(negedge clk);
         if (bus.op_1) seen = 1;
      end
      check("rst_mid_op1_seen", seen, 1);
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      check("rst_mid_busy", int'(bus.busy), 0);
      check("rst_mid_re", int'(bus.Read_Enable), 0);

      // T6: bypass pass-through
      @(posedge clk); #1 bus.start = 1; bus.bypass = 1; bus.Empty = 1;
      @(posedge clk); #1 bus.start = 0;
      for (int i = 0; i < 8; i++) begin
         bus.Empty = pat[i][1];
         bus.Afull = pat[i][0];
         if (pat[i] == 2'b00) push_wr(0, 0, 0, -1);
         @(negedge clk);
         check("t6_re", int'(bus.Read_Enable), (pat[i] == 2'b00) ? 1 : 0);
         check("t6_we", int'(bus.Write_Enable), (pat[i] == 2'b00) ? 1 : 0);
         check("t6_stop_empty", int'(bus.stop_empty), int'(pat[i][1]));
         check("t6_stop_afull", int'(bus.stop_Afull), int'(pat[i][0]));
         @(posedge clk); #1;
      end
      bus.Empty = 0; bus.Afull = 1;
      pulse_stop();
      @(negedge clk);
      check("t6_idle_busy", int'(bus.busy), 0);
      check("t6_writes_left", wr_q.size(), 0);
      bus.bypass = 0; bus.Afull = 0;

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
